// File: rtl/wb_stage.sv
// Writeback stage: holds the memory-stage result for one cycle, commits it to the
// register file, counts retired instructions, and serves two bypassed read ports.
module wb_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned CNT_W = 64,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [AW-1:0]    rd_i,
  input  logic             reg_we_i,
  input  logic [XLEN-1:0]  result_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic [AW-1:0]    rs1_addr_i,
  input  logic [AW-1:0]    rs2_addr_i,
  output logic [XLEN-1:0]  rs1_data_o,
  output logic [XLEN-1:0]  rs2_data_o,
  output logic             wb_valid_o,
  output logic [AW-1:0]    wb_rd_o,
  output logic             wb_we_o,
  output logic [XLEN-1:0]  wb_data_o,
  output logic [CNT_W-1:0] instret_o
);

  logic             wb_valid_q;
  logic [AW-1:0]    wb_rd_q;
  logic             wb_we_q;
  logic [XLEN-1:0]  wb_data_q;
  logic [CNT_W-1:0] instret_q;
  // x0 has no storage; reads of address 0 are forced to zero.
  logic [XLEN-1:0]  regs_q [1:NREGS-1];

  logic commit;
  logic rf_we;
  logic cap_valid;

  assign commit    = wb_valid_q & ~stall_i;
  assign rf_we     = commit & wb_we_q & (wb_rd_q != '0);
  assign cap_valid = valid_i & ~flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_we_q    <= 1'b0;
      wb_data_q  <= '0;
      instret_q  <= '0;
      for (int unsigned i = 1; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      if (commit) begin
        instret_q <= instret_q + CNT_W'(1);
      end
      if (rf_we) begin
        regs_q[wb_rd_q] <= wb_data_q;
      end
      // Capture happens on the same edge as the commit of the previous entry.
      if (!stall_i) begin
        wb_valid_q <= cap_valid;
        wb_rd_q    <= rd_i;
        wb_we_q    <= reg_we_i & cap_valid;
        wb_data_q  <= result_i;
      end
    end
  end

  // Bypass applies whether or not the held entry commits this cycle.
  always_comb begin
    rs1_data_o = '0;
    rs2_data_o = '0;
    if (rs1_addr_i != '0) begin
      if (wb_valid_q && wb_we_q && (wb_rd_q == rs1_addr_i)) begin
        rs1_data_o = wb_data_q;
      end else begin
        rs1_data_o = regs_q[rs1_addr_i];
      end
    end
    if (rs2_addr_i != '0) begin
      if (wb_valid_q && wb_we_q && (wb_rd_q == rs2_addr_i)) begin
        rs2_data_o = wb_data_q;
      end else begin
        rs2_data_o = regs_q[rs2_addr_i];
      end
    end
  end

  assign wb_valid_o = wb_valid_q;
  assign wb_rd_o    = wb_rd_q;
  assign wb_we_o    = wb_we_q;
  assign wb_data_o  = wb_data_q;
  assign instret_o  = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios then randomized traffic, all checked against
// an architectural model (pending-instruction record plus register array and counter).
module tb_wb_stage;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned CNT_MOD = 1 << CNT_W;

  logic             clk;
  logic             rst_i;
  logic             valid_i;
  logic [4:0]       rd_i;
  logic             reg_we_i;
  logic [XLEN-1:0]  result_i;
  logic             stall_i;
  logic             flush_i;
  logic [4:0]       rs1_addr_i;
  logic [4:0]       rs2_addr_i;
  logic [XLEN-1:0]  rs1_data_o;
  logic [XLEN-1:0]  rs2_data_o;
  logic             wb_valid_o;
  logic [4:0]       wb_rd_o;
  logic             wb_we_o;
  logic [XLEN-1:0]  wb_data_o;
  logic [CNT_W-1:0] instret_o;

  wb_stage #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .CNT_W (CNT_W)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .valid_i    (valid_i),
    .rd_i       (rd_i),
    .reg_we_i   (reg_we_i),
    .result_i   (result_i),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .rs1_addr_i (rs1_addr_i),
    .rs2_addr_i (rs2_addr_i),
    .rs1_data_o (rs1_data_o),
    .rs2_data_o (rs2_data_o),
    .wb_valid_o (wb_valid_o),
    .wb_rd_o    (wb_rd_o),
    .wb_we_o    (wb_we_o),
    .wb_data_o  (wb_data_o),
    .instret_o  (instret_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: the one in-flight instruction plus architectural state.
  bit          m_valid;
  int unsigned m_rd;
  bit          m_we;
  int unsigned m_data;
  int unsigned m_instret;
  int unsigned m_regs [NREGS];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned model_read(input int unsigned addr);
    if (addr == 0) return 0;
    if (m_valid && m_we && m_rd == addr) return m_data;
    return m_regs[addr];
  endfunction

  task automatic model_edge();
    if (rst_i) begin
      m_valid = 0; m_rd = 0; m_we = 0; m_data = 0; m_instret = 0;
      foreach (m_regs[i]) m_regs[i] = 0;
    end else if (!stall_i) begin
      if (m_valid) begin
        m_instret = (m_instret + 1) % CNT_MOD;
        if (m_we && m_rd != 0) m_regs[m_rd] = m_data;
      end
      m_valid = valid_i && !flush_i;
      m_rd    = rd_i;
      m_we    = reg_we_i && valid_i && !flush_i;
      m_data  = result_i;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".wb_valid"}, 64'(wb_valid_o), 64'(m_valid));
    check({tag, ".wb_rd"},    64'(wb_rd_o),    64'(m_rd));
    check({tag, ".wb_we"},    64'(wb_we_o),    64'(m_we));
    check({tag, ".wb_data"},  64'(wb_data_o),  64'(m_data));
    check({tag, ".instret"},  64'(instret_o),  64'(m_instret));
    check({tag, ".rs1"},      64'(rs1_data_o), 64'(model_read(rs1_addr_i)));
    check({tag, ".rs2"},      64'(rs2_data_o), 64'(model_read(rs2_addr_i)));
  endtask

  task automatic cycle(input string tag, input logic v, input logic [4:0] rd, input logic we,
                       input logic [31:0] d, input logic st, input logic fl, input logic r);
    valid_i = v; rd_i = rd; reg_we_i = we; result_i = d;
    stall_i = st; flush_i = fl; rst_i = r;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    valid_i = 0; rd_i = 0; reg_we_i = 0; result_i = 0; stall_i = 0; flush_i = 0;
    rst_i = 1; rs1_addr_i = 0; rs2_addr_i = 0;
    m_valid = 0; m_rd = 0; m_we = 0; m_data = 0; m_instret = 0;
    foreach (m_regs[i]) m_regs[i] = 0;

    cycle("reset", 0, 0, 0, 0, 0, 0, 1);
    check("reset.instret0", 64'(instret_o), 64'd0);

    // Reset while an entry is pending discards it.
    rs1_addr_i = 3;
    cycle("rmid_load", 1, 3, 1, 32'hAA, 0, 0, 0);
    check("rmid.bypass", 64'(rs1_data_o), 64'hAA);
    cycle("rmid_rst", 0, 0, 0, 0, 0, 0, 1);
    check("rmid.valid", 64'(wb_valid_o), 64'd0);
    check("rmid.instret", 64'(instret_o), 64'd0);
    check("rmid.x3", 64'(rs1_data_o), 64'd0);

    // Back-to-back writes.
    rs1_addr_i = 5; rs2_addr_i = 6;
    cycle("b2b_a", 1, 5, 1, 32'h11111111, 0, 0, 0);
    cycle("b2b_b", 1, 6, 1, 32'h22222222, 0, 0, 0);
    check("b2b.x5", 64'(rs1_data_o), 64'h11111111);
    cycle("b2b_c", 0, 0, 0, 0, 0, 0, 0);
    check("b2b.x6", 64'(rs2_data_o), 64'h22222222);
    check("b2b.instret", 64'(instret_o), 64'd2);

    // Bypass while stalled; commit only once stall releases.
    rs1_addr_i = 7; rs2_addr_i = 0;
    cycle("byp_load", 1, 7, 1, 32'hDEADBEEF, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cycle("byp_stall", 1, 8, 1, 32'h123, 1, 0, 0);
      check("byp.rs1", 64'(rs1_data_o), 64'hDEADBEEF);
      check("byp.instret", 64'(instret_o), 64'd2);
    end
    cycle("byp_go", 0, 0, 0, 0, 0, 0, 0);
    check("byp.instret_inc", 64'(instret_o), 64'd3);
    check("byp.rf", 64'(rs1_data_o), 64'hDEADBEEF);

    // x0 writes dropped but counted.
    rs1_addr_i = 0; rs2_addr_i = 0;
    cycle("x0_load", 1, 0, 1, 32'hFFFFFFFF, 0, 0, 0);
    check("x0.rs1_held", 64'(rs1_data_o), 64'd0);
    cycle("x0_commit", 0, 0, 0, 0, 0, 0, 0);
    check("x0.rs2", 64'(rs2_data_o), 64'd0);
    check("x0.instret", 64'(instret_o), 64'd4);

    // Flush drops the incoming entry; the held one still commits.
    rs1_addr_i = 9; rs2_addr_i = 10;
    cycle("fl_hold", 1, 10, 1, 32'h77, 0, 0, 0);
    cycle("fl_flush", 1, 9, 1, 32'h5, 0, 1, 0);
    check("fl.valid", 64'(wb_valid_o), 64'd0);
    check("fl.we", 64'(wb_we_o), 64'd0);
    check("fl.instret", 64'(instret_o), 64'd5);
    cycle("fl_idle", 0, 0, 0, 0, 0, 0, 0);
    check("fl.x9", 64'(rs1_data_o), 64'd0);
    check("fl.x10", 64'(rs2_data_o), 64'h77);
    check("fl.instret_after", 64'(instret_o), 64'd5);

    // Flush during stall leaves the held entry alone.
    rs1_addr_i = 11;
    cycle("fs_load", 1, 11, 1, 32'h33, 0, 0, 0);
    cycle("fs_stall", 1, 12, 1, 32'h44, 1, 1, 0);
    check("fs.valid", 64'(wb_valid_o), 64'd1);
    check("fs.rd", 64'(wb_rd_o), 64'd11);
    cycle("fs_go", 0, 0, 0, 0, 0, 0, 0);
    check("fs.x11", 64'(rs1_data_o), 64'h33);
    check("fs.instret", 64'(instret_o), 64'd6);

    // Counter wrap.
    for (int k = 0; k < 40 && m_instret != CNT_MOD - 1; k++) begin
      cycle("wrap_fill", 1, 0, 0, 0, 0, 0, 0);
    end
    check("wrap.max", 64'(instret_o), 64'(CNT_MOD - 1));
    cycle("wrap_last", 1, 0, 0, 0, 0, 0, 0);
    check("wrap.zero", 64'(instret_o), 64'd0);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      logic [4:0] r1;
      r1 = 5'($urandom_range(0, 31));
      rs1_addr_i = r1;
      rs2_addr_i = ($urandom_range(0, 1) == 1) ? 5'(m_rd) : 5'($urandom_range(0, 31));
      cycle("rand",
            1'($urandom_range(0, 3) != 0),
            5'($urandom_range(0, 31)),
            1'($urandom_range(0, 3) != 0),
            32'($urandom),
            1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 6) == 0),
            1'($urandom_range(0, 60) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
Writeback stage placed directly downstream of the memory stage. It registers the memory stage's result, commits it to the architectural register file, and counts retired instructions. It also provides the two combinational register-file read ports used by decode, with same-cycle writeback bypass, and exports the in-flight writeback entry to the hazard/forwarding logic.

Parameters:
XLEN, 32, data width of registers and results
NREGS, 32, number of architectural registers (address width = clog2(NREGS) = 5)
CNT_W, 64, width of the retired-instruction counter

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  reset, synchronous, active-high
valid_i  in  1  memory stage presents a valid instruction this cycle
rd_i  in  5  destination register of incoming instruction
reg_we_i  in  1  incoming instruction writes the register file
result_i  in  XLEN  memory stage result (ALU result or load data)
stall_i  in  1  hold writeback register; no commit this cycle
flush_i  in  1  discard the incoming instruction
rs1_addr_i  in  5  read port 1 address
rs2_addr_i  in  5  read port 2 address
rs1_data_o  out  XLEN  read port 1 data, combinational
rs2_data_o  out  XLEN  read port 2 data, combinational
wb_valid_o  out  1  writeback register holds a valid entry
wb_rd_o  out  5  rd of held entry
wb_we_o  out  1  held entry writes the register file
wb_data_o  out  XLEN  result of held entry
instret_o  out  CNT_W  retired-instruction count

Behaviour:
- Reset when rst_i=1 at an edge:
  - wb_valid_o, wb_we_o and instret_o go to 0; wb_rd_o and wb_data_o go to 0.
  - All NREGS registers go to 0.
  - Reset has priority over every other input. A held entry is discarded without commit.
- Commit condition: wb_valid_o=1 and stall_i=0.
  - At that edge, instret_o increments by 1, including for entries with we=0 or rd=0.
  - If wb_we_o=1 and wb_rd_o!=0, the regfile at wb_rd_o is written with wb_data_o.
- Capture, when stall_i=0 at an edge:
  - The register loads rd_i, reg_we_i and result_i.
  - wb_valid_o loads valid_i & ~flush_i.
  - A flushed or invalid capture leaves wb_we_o forced to 0.
- Stall, when stall_i=1:
  - Register contents hold and no commit occurs.
  - Incoming instruction is ignored; upstream holds it.
  - flush_i together with stall_i has no effect on the held entry.
- Latency: an instruction presented with valid_i at edge N appears on wb_* after edge N. With no stall it commits at edge N+1. The regfile reflects the write after edge N+1.
- Read ports: x0 always reads 0.
  - Bypass: if wb_valid_o & wb_we_o & (wb_rd_o==addr) & (addr!=0), return wb_data_o. This holds even while stalled.
  - Otherwise return the regfile contents.
- instret_o wraps modulo 2^CNT_W with no saturation.
- Writes to x0 are dropped; storage for x0 need not exist.
- Simultaneous commit and capture is the normal case. The old entry commits and the new entry loads at the same edge.

Test Plan:
- Reset mid-operation:
  - Stimulus: load a valid entry (rd=3, we=1, data=0xAA) and assert rst_i before it commits.
  - Required response: wb_valid_o=0, instret_o=0 and x3 reads 0 after the reset edge.
- Back-to-back writeback:
  - Stimulus: valid writes x5=0x11111111, then x6=0x22222222 on consecutive cycles.
  - Required response: x5 and x6 read the values two edges after their capture, and instret_o=2.
- Bypass:
  - Stimulus: capture x7=0xDEADBEEF with stall_i=1 held and rs1_addr_i=7.
  - Required response: rs1_data_o=0xDEADBEEF while stalled; instret_o stays unchanged until stall_i drops, then increments once.
- x0 handling:
  - Stimulus: valid write rd=0, data=0xFFFFFFFF.
  - Required response: rs1/rs2 reading 0 return 0 before and after, and instret_o still increments.
- Flush:
  - Stimulus: valid_i=1, flush_i=1, rd=9, data=0x5.
  - Required response: wb_valid_o=0, x9 unchanged and instret_o unchanged. An entry already held when the flush arrives still commits.
- Counter wrap:
  - Stimulus: force instret_o to 2^CNT_W-1 (or parameterise CNT_W=4 and retire 16).
  - Required response: the next commit yields instret_o=0.
